// File: rtl/sdhci_cmd_sequencer.sv
// SD command issue sequencer: CMD PHY handshake, response timeout, R1b busy,
// data-phase tracking, Auto CMD12 issue and Present State inhibit flags.
module sdhci_cmd_sequencer #(
  parameter int RESP_TIMEOUT = 64,
  parameter int TO_W         = 7
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cmd_write_i,
  input  logic [5:0]  cmd_index_i,
  input  logic [31:0] cmd_arg_i,
  input  logic [1:0]  resp_type_i,
  input  logic        data_present_i,
  input  logic        auto_cmd12_en_i,
  output logic        phy_start_o,
  input  logic        phy_ready_i,
  output logic [5:0]  phy_index_o,
  output logic [31:0] phy_arg_o,
  output logic [1:0]  phy_resp_type_o,
  input  logic        phy_done_i,
  input  logic        phy_crc_err_i,
  input  logic        phy_end_err_i,
  input  logic        phy_index_err_i,
  input  logic        dat0_busy_i,
  input  logic        dat_done_i,
  input  logic        dat_err_i,
  output logic        cmd_inhibit_cmd_o,
  output logic        cmd_inhibit_dat_o,
  output logic        cmd_complete_o,
  output logic [3:0]  cmd_err_o,
  output logic [5:0]  ac12_err_o
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_BUSY} state_e;

  localparam logic [TO_W-1:0] CNT_LAST = TO_W'(RESP_TIMEOUT - 1);
  localparam logic [1:0]      RT_NONE  = 2'b00;
  localparam logic [1:0]      RT_BUSY  = 2'b11;

  state_e          state_q, state_d;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic [5:0]      idx_q, idx_d;
  logic [31:0]     arg_q, arg_d;
  logic [1:0]      type_q, type_d;
  logic            cur_data_q, cur_data_d;
  logic            ac12_en_q, ac12_en_d;
  logic            ac12_run_q, ac12_run_d;
  logic            resp_ok_q, resp_ok_d;
  logic            data_active_q, data_active_d;
  logic            ac12_pend_q, ac12_pend_d;
  logic            inh_cmd_q, inh_cmd_d;
  logic            inh_dat_q, inh_dat_d;
  logic            cmd_complete_q, cmd_complete_d;
  logic [3:0]      cmd_err_q, cmd_err_d;
  logic [5:0]      ac12_err_q, ac12_err_d;

  logic       can_accept;
  logic       accepted;
  logic       finish;
  logic       fin_ok;
  logic [2:0] resp_errs;

  assign resp_errs  = {phy_index_err_i, phy_end_err_i, phy_crc_err_i};
  // Busy-type commands also need the DAT line, so they wait like data commands.
  assign can_accept = (state_q == S_IDLE) && !inh_cmd_q && !ac12_pend_q &&
                      !((data_present_i || resp_type_i == RT_BUSY) && inh_dat_q);

  // NOTE: every variable gets a default before the case, so no path can infer a latch.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    idx_d          = idx_q;
    arg_d          = arg_q;
    type_d         = type_q;
    cur_data_d     = cur_data_q;
    ac12_en_d      = ac12_en_q;
    ac12_run_d     = ac12_run_q;
    resp_ok_d      = resp_ok_q;
    data_active_d  = data_active_q;
    ac12_pend_d    = ac12_pend_q;
    inh_cmd_d      = inh_cmd_q;
    cmd_complete_d = 1'b0;
    cmd_err_d      = 4'b0;
    ac12_err_d     = 6'b0;
    accepted       = 1'b0;
    finish         = 1'b0;
    fin_ok         = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (ac12_pend_q) begin
          state_d    = S_ISSUE;
          idx_d      = 6'd12;
          arg_d      = 32'h0;
          type_d     = RT_BUSY;
          cur_data_d = 1'b0;
          ac12_run_d = 1'b1;
          inh_cmd_d  = 1'b1;
        end else if (cmd_write_i && can_accept) begin
          accepted   = 1'b1;
          state_d    = S_ISSUE;
          idx_d      = cmd_index_i;
          arg_d      = cmd_arg_i;
          type_d     = resp_type_i;
          cur_data_d = data_present_i;
          ac12_run_d = 1'b0;
          inh_cmd_d  = 1'b1;
          if (data_present_i) ac12_en_d = auto_cmd12_en_i;
        end
      end
      S_ISSUE: begin
        if (phy_ready_i) begin
          state_d = S_WAIT;
          cnt_d   = '0;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (phy_done_i) begin
          resp_ok_d = (resp_errs == 3'b000);
          if (ac12_run_q) ac12_err_d[4:2] = resp_errs;
          else            cmd_err_d[3:1]  = resp_errs;
          if (resp_errs == 3'b000 && cur_data_q && !ac12_run_q) data_active_d = 1'b1;
          if (type_q == RT_BUSY) begin
            state_d = S_BUSY;
          end else begin
            finish = 1'b1;
            fin_ok = (resp_errs == 3'b000);
          end
        end else if (type_q != RT_NONE && cnt_q == CNT_LAST) begin
          if (ac12_run_q) ac12_err_d[1] = 1'b1;
          else            cmd_err_d[0]  = 1'b1;
          data_active_d = 1'b0;
          resp_ok_d     = 1'b0;
          finish        = 1'b1;
        end
      end
      S_BUSY: begin
        if (!dat0_busy_i) begin
          finish = 1'b1;
          fin_ok = resp_ok_q;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (finish) begin
      state_d   = S_IDLE;
      inh_cmd_d = 1'b0;
      if (ac12_run_q) begin
        ac12_pend_d = 1'b0;
        ac12_run_d  = 1'b0;
      end else begin
        cmd_complete_d = fin_ok;
      end
    end

    if (cmd_write_i && !accepted && ac12_run_q) ac12_err_d[5] = 1'b1;

    if (dat_done_i && data_active_q) begin
      data_active_d = 1'b0;
      if (ac12_en_q) begin
        if (dat_err_i) ac12_err_d[0] = 1'b1;
        else           ac12_pend_d   = 1'b1;
      end
    end

    // DAT stays inhibited while anything still owns the DAT lines.
    inh_dat_d = data_active_d || ac12_pend_d ||
                ((state_d != S_IDLE) && (cur_data_d || type_d == RT_BUSY));
  end

  // NOTE: sequential state uses non-blocking assignments only; the reset is synchronous.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      idx_q          <= '0;
      arg_q          <= '0;
      type_q         <= '0;
      cur_data_q     <= 1'b0;
      ac12_en_q      <= 1'b0;
      ac12_run_q     <= 1'b0;
      resp_ok_q      <= 1'b0;
      data_active_q  <= 1'b0;
      ac12_pend_q    <= 1'b0;
      inh_cmd_q      <= 1'b0;
      inh_dat_q      <= 1'b0;
      cmd_complete_q <= 1'b0;
      cmd_err_q      <= '0;
      ac12_err_q     <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      idx_q          <= idx_d;
      arg_q          <= arg_d;
      type_q         <= type_d;
      cur_data_q     <= cur_data_d;
      ac12_en_q      <= ac12_en_d;
      ac12_run_q     <= ac12_run_d;
      resp_ok_q      <= resp_ok_d;
      data_active_q  <= data_active_d;
      ac12_pend_q    <= ac12_pend_d;
      inh_cmd_q      <= inh_cmd_d;
      inh_dat_q      <= inh_dat_d;
      cmd_complete_q <= cmd_complete_d;
      cmd_err_q      <= cmd_err_d;
      ac12_err_q     <= ac12_err_d;
    end
  end

  assign phy_start_o       = (state_q == S_ISSUE);
  assign phy_index_o       = idx_q;
  assign phy_arg_o         = arg_q;
  assign phy_resp_type_o   = type_q;
  assign cmd_inhibit_cmd_o = inh_cmd_q;
  assign cmd_inhibit_dat_o = inh_dat_q;
  assign cmd_complete_o    = cmd_complete_q;
  assign cmd_err_o         = cmd_err_q;
  assign ac12_err_o        = ac12_err_q;

endmodule

// File: tb/tb_sdhci_cmd_sequencer.sv
// Directed bench for sdhci_cmd_sequencer: outputs sampled 1ns after each rising edge.
module tb_sdhci_cmd_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_write;
  logic [5:0]  cmd_index;
  logic [31:0] cmd_arg;
  logic [1:0]  resp_type;
  logic        data_present;
  logic        auto_cmd12_en;
  logic        phy_start;
  logic        phy_ready;
  logic [5:0]  phy_index;
  logic [31:0] phy_arg;
  logic [1:0]  phy_resp_type;
  logic        phy_done;
  logic        phy_crc_err;
  logic        phy_end_err;
  logic        phy_index_err;
  logic        dat0_busy;
  logic        dat_done;
  logic        dat_err;
  logic        inh_cmd;
  logic        inh_dat;
  logic        cmd_complete;
  logic [3:0]  cmd_err;
  logic [5:0]  ac12_err;

  int n_checks = 0;
  int n_pass   = 0;
  logic [3:0] err_acc;

  always #5 clk = ~clk;

  sdhci_cmd_sequencer #(.RESP_TIMEOUT(64), .TO_W(7)) dut (
    .clk_i(clk), .rst_i(rst),
    .cmd_write_i(cmd_write), .cmd_index_i(cmd_index), .cmd_arg_i(cmd_arg),
    .resp_type_i(resp_type), .data_present_i(data_present), .auto_cmd12_en_i(auto_cmd12_en),
    .phy_start_o(phy_start), .phy_ready_i(phy_ready), .phy_index_o(phy_index),
    .phy_arg_o(phy_arg), .phy_resp_type_o(phy_resp_type), .phy_done_i(phy_done),
    .phy_crc_err_i(phy_crc_err), .phy_end_err_i(phy_end_err), .phy_index_err_i(phy_index_err),
    .dat0_busy_i(dat0_busy), .dat_done_i(dat_done), .dat_err_i(dat_err),
    .cmd_inhibit_cmd_o(inh_cmd), .cmd_inhibit_dat_o(inh_dat),
    .cmd_complete_o(cmd_complete), .cmd_err_o(cmd_err), .ac12_err_o(ac12_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_cmd(input logic [5:0] idx, input logic [31:0] arg,
                           input logic [1:0] typ, input logic dp, input logic ac12);
    cmd_index = idx; cmd_arg = arg; resp_type = typ;
    data_present = dp; auto_cmd12_en = ac12; cmd_write = 1'b1;
    tick();
    cmd_write = 1'b0;
  endtask

  initial begin
    rst = 1'b1; cmd_write = 0; cmd_index = 0; cmd_arg = 0; resp_type = 0;
    data_present = 0; auto_cmd12_en = 0; phy_ready = 0; phy_done = 0;
    phy_crc_err = 0; phy_end_err = 0; phy_index_err = 0;
    dat0_busy = 0; dat_done = 0; dat_err = 0;
    tick(); tick();
    check("rst_start", phy_start, 0);
    check("rst_inh", {inh_cmd, inh_dat}, 0);
    check("rst_pulses", {cmd_complete, cmd_err, ac12_err}, 0);
    rst = 1'b0;
    tick();

    // CMD8: ready two cycles after accept, done five cycles after accept
    write_cmd(6'd8, 32'h1AA, 2'b10, 0, 0);
    check("c8_start", phy_start, 1);
    check("c8_inh_cmd", inh_cmd, 1);
    check("c8_fields", {phy_index, phy_resp_type}, {6'd8, 2'b10});
    check("c8_arg", phy_arg, 32'h1AA);
    check("c8_inh_dat", inh_dat, 0);
    tick();
    check("c8_hold", {phy_start, phy_index}, {1'b1, 6'd8});
    phy_ready = 1; tick(); phy_ready = 0;
    check("c8_start_drop", phy_start, 0);
    tick(); tick();
    check("c8_inh_pre", {inh_cmd, cmd_complete}, {1'b1, 1'b0});
    phy_done = 1; tick(); phy_done = 0;
    check("c8_done", {inh_cmd, cmd_complete, cmd_err}, {1'b0, 1'b1, 4'b0});
    tick();
    check("c8_pulse_end", cmd_complete, 0);

    // Response timeout at accept+1+RESP_TIMEOUT
    phy_ready = 1;
    write_cmd(6'd8, 32'h1AA, 2'b10, 0, 0);
    err_acc = 0;
    for (int i = 0; i < 64; i++) begin tick(); err_acc |= cmd_err; end
    check("to_early", {err_acc, inh_cmd}, {4'b0, 1'b1});
    tick();
    check("to_err", cmd_err, 4'b0001);
    check("to_inh", {inh_cmd, cmd_complete, inh_dat}, 0);

    // Done on the timeout cycle wins
    write_cmd(6'd8, 32'h1AA, 2'b10, 0, 0);
    for (int i = 0; i < 64; i++) tick();
    phy_done = 1; tick(); phy_done = 0;
    check("to_tie", {cmd_err, cmd_complete, inh_cmd}, {4'b0, 1'b1, 1'b0});

    // CRC error on a user command
    write_cmd(6'd13, 32'h10000, 2'b10, 0, 0);
    tick();
    phy_done = 1; phy_crc_err = 1; tick(); phy_done = 0; phy_crc_err = 0;
    check("crc_err", {cmd_err, cmd_complete}, {4'b0010, 1'b0});
    phy_ready = 0;
    tick();

    // CMD18 with Auto CMD12
    write_cmd(6'd18, 32'h400, 2'b10, 1, 1);
    check("c18_inh_dat", inh_dat, 1);
    phy_ready = 1; tick(); phy_ready = 0;
    phy_done = 1; tick(); phy_done = 0;
    check("c18_done", {cmd_complete, inh_cmd, inh_dat}, {1'b1, 1'b0, 1'b1});
    tick(); tick();
    check("c18_data_hold", {inh_dat, phy_start}, {1'b1, 1'b0});
    dat_done = 1; tick(); dat_done = 0;
    check("c18_dat_done", inh_dat, 1);
    tick();
    check("ac12_start", {phy_start, phy_index, phy_resp_type}, {1'b1, 6'd12, 2'b11});
    check("ac12_arg", phy_arg, 0);
    check("ac12_inh", {inh_cmd, inh_dat}, 2'b11);
    phy_ready = 1; tick(); phy_ready = 0;
    write_cmd(6'd13, 32'h0, 2'b10, 0, 0);
    check("ac12_reject", {ac12_err, phy_start}, {6'b100000, 1'b0});
    phy_done = 1; dat0_busy = 1; tick(); phy_done = 0;
    check("ac12_resp", {ac12_err, cmd_complete, cmd_err}, 0);
    for (int i = 0; i < 10; i++) tick();
    check("ac12_busy", {inh_cmd, inh_dat}, 2'b11);
    dat0_busy = 0; tick();
    check("ac12_exit", {inh_cmd, inh_dat, cmd_complete, ac12_err}, 0);

    // Data error with Auto CMD12 enabled: CMD12 not executed
    phy_ready = 1;
    write_cmd(6'd18, 32'h800, 2'b10, 1, 1);
    tick(); phy_ready = 0;
    phy_done = 1; tick(); phy_done = 0;
    dat_done = 1; dat_err = 1; tick(); dat_done = 0; dat_err = 0;
    check("daterr_ac12", ac12_err, 6'b000001);
    check("daterr_inh", inh_dat, 0);
    tick();
    check("daterr_no12", {phy_start, inh_cmd, ac12_err}, 0);

    // Second write during user ISSUE ignored, then reset mid-ISSUE
    write_cmd(6'd2, 32'h0, 2'b01, 0, 0);
    write_cmd(6'd9, 32'h5, 2'b10, 0, 0);
    check("issue_ignore", {phy_start, phy_index, phy_resp_type}, {1'b1, 6'd2, 2'b01});
    check("issue_silent", {ac12_err, cmd_err}, 0);
    rst = 1; tick(); rst = 0;
    check("midrst", {phy_start, inh_cmd, inh_dat, phy_index, phy_resp_type}, 0);
    check("midrst_arg", phy_arg, 0);

    // CMD0 after reset, type 00 never times out
    write_cmd(6'd0, 32'h0, 2'b00, 0, 0);
    check("c0_accept", {phy_start, inh_cmd, phy_index}, {1'b1, 1'b1, 6'd0});
    phy_ready = 1; tick(); phy_ready = 0;
    err_acc = 0;
    for (int i = 0; i < 70; i++) begin tick(); err_acc |= cmd_err; end
    check("c0_no_to", {err_acc, inh_cmd}, {4'b0, 1'b1});
    phy_done = 1; tick(); phy_done = 0;
    check("c0_done", {cmd_complete, inh_cmd}, {1'b1, 1'b0});

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
